// File: rtl/uart_rx.sv
// uart_rx: UART receiver, idle-high line, LSB first, one mid-bit sample per bit.
//   Default frame is 8N1; defining UART_RX_PARITY_EN selects 8E1 (even parity)
//   and adds the parity_err output.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rxd             serial line (asynchronous to clk, idle 1)
//   period[15:0]    clk cycles per bit (4..65535), latched at start detect
//   rx_ack          consumer takes rx_data (honoured only while rx_valid)
//   rx_data[7:0]    received byte, stable while rx_valid
//   rx_valid        byte available, held until rx_ack
//   overrun         sticky, a byte was overwritten before ack, cleared by rx_ack
//   frame_err       1-cycle pulse, stop bit sampled 0
//   parity_err      1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//   busy            receiver not idle
module uart_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rxd,
   input  logic [15:0] period,
   input  logic        rx_ack,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        overrun,
   output logic        frame_err,
`ifdef UART_RX_PARITY_EN
   output logic        parity_err,
`endif
   output logic        busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
`ifdef UART_RX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = STOP;
`endif
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic rxs, rxs_prev_q, fall;
   logic [15:0] period_q, period_d, cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
   logic rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
   logic counting, tick, stop_tick, par_ok, deliver, start_det;
`ifdef UART_RX_PARITY_EN
   logic par_q, par_d, parity_err_q, parity_err_d;
`endif
   // Synchronizer resets to the idle level so reset release never looks like a start edge
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sync_q     <= '1;
         rxs_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], rxd};
         rxs_prev_q <= rxs;
      end
   assign rxs  = sync_q[SYNC_STAGES-1];
   assign fall = rxs_prev_q & ~rxs;
   always_ff @(posedge clk or posedge rst)
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall) state_d = START;
         START:   if (tick) state_d = rxs ? IDLE : DATA;
         DATA:    if (tick && idx_q == 3'd7) state_d = AFTER_DATA;
         PARITY:  if (tick) state_d = STOP;
         STOP:    if (tick) state_d = rxs ? IDLE : BRK;
         BRK:     if (rxs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      counting  = state_q inside {START, DATA, PARITY, STOP};
      tick      = counting && cnt_q == period_q - 16'd1;
      busy      = state_q != IDLE;
      start_det = state_q == IDLE && fall;
      stop_tick = state_q == STOP && tick;
`ifdef UART_RX_PARITY_EN
      par_ok    = par_q == ^shift_q;
`else
      par_ok    = 1'b1;
`endif
      deliver   = stop_tick && par_ok;
   end
   // Reload places the first tick half a bit after the start edge, then one per bit
   always_comb begin
      period_d    = start_det ? period : period_q;
      cnt_d       = start_det ? period - (period >> 1) - 16'd1 : tick ? 16'd0 : counting ? cnt_q + 16'd1 : cnt_q;
      idx_d       = state_q == START ? 3'd0 : (state_q == DATA && tick) ? idx_q + 3'd1 : idx_q;
      shift_d     = (state_q == DATA && tick) ? {rxs, shift_q[7:1]} : shift_q;
      rx_data_d   = deliver ? shift_q : rx_data_q;
      rx_valid_d  = deliver | (rx_valid_q & ~rx_ack);
      overrun_d   = deliver ? rx_valid_q & ~rx_ack : overrun_q & ~rx_ack;
      frame_err_d = stop_tick & ~rxs;
`ifdef UART_RX_PARITY_EN
      par_d        = (state_q == PARITY && tick) ? rxs : par_q;
      parity_err_d = stop_tick & ~par_ok;
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         period_q    <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q        <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         period_q    <= period_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
         par_q        <= par_d;
         parity_err_q <= parity_err_d;
`endif
      end
   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif
endmodule
